// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment readback path: active-high segment patterns,
// special decode codes and the frame-assembly state encoding.
package seg_scan_pkg;

    localparam logic [6:0] PAT_0     = 7'b0111111;
    localparam logic [6:0] PAT_1     = 7'b0000110;
    localparam logic [6:0] PAT_2     = 7'b1011011;
    localparam logic [6:0] PAT_3     = 7'b1001111;
    localparam logic [6:0] PAT_4     = 7'b1100110;
    localparam logic [6:0] PAT_5     = 7'b1101101;
    localparam logic [6:0] PAT_6     = 7'b1111101;
    localparam logic [6:0] PAT_7     = 7'b0000111;
    localparam logic [6:0] PAT_8     = 7'b1111111;
    localparam logic [6:0] PAT_9     = 7'b1101111;
    localparam logic [6:0] PAT_DASH  = 7'b1000000;
    localparam logic [6:0] PAT_BLANK = 7'b0000000;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FILL  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the display driver's segment encoder: active-low
// pattern in, 4-bit code out (unrecognised patterns map to CODE_ERR).
module seg_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code
);

    logic [6:0] pat_s;

    // Invert to active-high and match against the known glyphs.
    always_comb begin
        pat_s = ~seg_n;
        case (pat_s)
            PAT_0:     code = 4'h0;
            PAT_1:     code = 4'h1;
            PAT_2:     code = 4'h2;
            PAT_3:     code = 4'h3;
            PAT_4:     code = 4'h4;
            PAT_5:     code = 4'h5;
            PAT_6:     code = 4'h6;
            PAT_7:     code = 4'h7;
            PAT_8:     code = 4'h8;
            PAT_9:     code = 4'h9;
            PAT_DASH:  code = CODE_DASH;
            PAT_BLANK: code = CODE_BLANK;
            default:   code = CODE_ERR;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// Multiplexed 7-segment bus receiver: glitch filter, decode and frame assembly.
// Optional partial-frame timeout enabled by defining SEG_SCAN_RX_TIMEOUT_EN.
module seg_scan_rx
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned STABLE  = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  frame_valid,
    output logic                  err,
    output logic                  stale
);

    localparam int unsigned   CW       = $clog2(STABLE + 1);
    localparam int unsigned   KW       = DIGITS + 7;
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [KW-1:0]         key_q, key_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   work_q, work_d;
    logic [DIGITS-1:0]     seen_q, seen_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  fv_q, fv_d;
    logic                  err_q, err_d;
    logic                  stale_q, stale_d;
    scan_state_e           state_q, state_d;

    logic [3:0]            code_s;
    logic                  onehot_s;
    logic                  commit_s;
    logic                  timeout_s;
    logic                  err_any_s;
    logic [4*DIGITS-1:0]   work_next_s;
    logic [DIGITS-1:0]     seen_next_s;

    seg_pattern_decode u_decode (
        .seg_n (seg_n),
        .code  (code_s)
    );

    // Glitch filter: the counter only reaches STABLE once per distinct held key.
    always_comb begin
        key_d    = {dig_sel, seg_n};
        onehot_s = (dig_sel != '0) &&
                   ((dig_sel & (dig_sel - {{(DIGITS-1){1'b0}}, 1'b1})) == '0);
        if (!onehot_s) begin
            cnt_d = '0;
        end else if (key_d == key_q) begin
            cnt_d = (cnt_q == STABLE_C) ? STABLE_C : cnt_q + ONE_C;
        end else begin
            cnt_d = ONE_C;
        end
        commit_s = onehot_s && (cnt_d == STABLE_C) && (cnt_q == (STABLE_C - ONE_C));
    end

    // Working slots with this edge's commit folded in, so a completing commit lands in the frame.
    always_comb begin
        work_next_s = work_q;
        seen_next_s = seen_q;
        err_any_s   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (commit_s && dig_sel[i]) begin
                work_next_s[4*i +: 4] = code_s;
                seen_next_s[i]        = 1'b1;
            end else begin
                work_next_s[4*i +: 4] = work_q[4*i +: 4];
                seen_next_s[i]        = seen_q[i];
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (work_next_s[4*i +: 4] == CODE_ERR) begin
                err_any_s = 1'b1;
            end else begin
                err_any_s = err_any_s;
            end
        end
    end

`ifdef SEG_SCAN_RX_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic [IW-1:0] idle_inc_s;

    // Idle counter runs only while a partial frame is pending; any commit restarts it.
    always_comb begin
        idle_inc_s = idle_q + IW'(1);
        timeout_s  = (state_q == ST_FILL) && !commit_s && (idle_inc_s == IW'(TIMEOUT));
        if ((state_q == ST_FILL) && !commit_s && !timeout_s) begin
            idle_d = idle_inc_s;
        end else begin
            idle_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Frame assembly FSM: emit on full seen mask, drop the partial frame on timeout.
    always_comb begin
        state_d = state_q;
        work_d  = work_next_s;
        seen_d  = seen_next_s;
        bcd_d   = bcd_q;
        err_d   = err_q;
        fv_d    = 1'b0;
        stale_d = stale_q;
        case (state_q)
            ST_EMPTY: begin
                if (commit_s) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FILL: begin
                if (&seen_next_s) begin
                    bcd_d   = work_next_s;
                    err_d   = err_any_s;
                    fv_d    = 1'b1;
                    stale_d = 1'b0;
                    seen_d  = '0;
                    state_d = ST_EMPTY;
                end else if (timeout_s) begin
                    seen_d  = '0;
                    stale_d = 1'b1;
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                seen_d  = '0;
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and datapath registers, all on the falling sample edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            key_q   <= '0;
            cnt_q   <= '0;
            work_q  <= {DIGITS{CODE_BLANK}};
            seen_q  <= '0;
            bcd_q   <= {DIGITS{CODE_BLANK}};
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
            state_q <= ST_EMPTY;
        end else begin
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            seen_q  <= seen_d;
            bcd_q   <= bcd_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            stale_q <= stale_d;
            state_q <= state_d;
        end
    end

    assign bcd         = bcd_q;
    assign frame_valid = fv_q;
    assign err         = err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx (DIGITS=4, STABLE=3, TIMEOUT=64); expectations
// adapt to whether SEG_SCAN_RX_TIMEOUT_EN is defined.
module tb_seg_scan_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  dig_sel;
    logic [15:0] bcd;
    logic        frame_valid;
    logic        err;
    logic        stale;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEG_SCAN_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    seg_scan_rx #(.DIGITS(4), .STABLE(3), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .bcd         (bcd),
        .frame_valid (frame_valid),
        .err         (err),
        .stale       (stale)
    );

    typedef struct {
        logic [3:0]  sel;
        int          digit;
        int          hold;
        int          exp_fv;
        logic [15:0] exp_bcd;
        logic        exp_err;
        logic        exp_stale;
    } vec_t;

    vec_t vecs[$];

    // Active-low bus value for a glyph: 0-9, 10 dash, 11 blank, 12 bad pattern.
    function automatic logic [6:0] sn_of(input int d);
        logic [6:0] p;
        case (d)
            0:       p = 7'b0111111;
            1:       p = 7'b0000110;
            2:       p = 7'b1011011;
            3:       p = 7'b1001111;
            4:       p = 7'b1100110;
            5:       p = 7'b1101101;
            6:       p = 7'b1111101;
            7:       p = 7'b0000111;
            8:       p = 7'b1111111;
            9:       p = 7'b1101111;
            10:      p = 7'b1000000;
            11:      p = 7'b0000000;
            12:      p = 7'b0000001;
            default: p = 7'b0000000;
        endcase
        return ~p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] sel, input int digit, input int hold, input int fv,
                       input logic [15:0] b, input logic e, input logic s);
        vec_t v;
        v.sel = sel; v.digit = digit; v.hold = hold; v.exp_fv = fv;
        v.exp_bcd = b; v.exp_err = e; v.exp_stale = s;
        vecs.push_back(v);
    endtask

    // Hold one key for 'hold' falling edges, counting frame_valid pulses seen.
    task automatic apply(input logic [3:0] sel, input logic [6:0] sn, input int hold, output int fvs);
        fvs = 0;
        for (int i = 0; i < hold; i++) begin
            dig_sel = sel;
            seg_n   = sn;
            @(negedge clk);
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) fvs++;
        end
    endtask

    initial begin
        int fvs;
        int total;

        // Frame A: 1,2,3,4 with 4-edge holds
        add(4'b0001, 1, 4, 0, 16'hFFFF, 1'b0, 1'b0);
        add(4'b0010, 2, 4, 0, 16'hFFFF, 1'b0, 1'b0);
        add(4'b0100, 3, 4, 0, 16'hFFFF, 1'b0, 1'b0);
        add(4'b1000, 4, 4, 1, 16'h4321, 1'b0, 1'b0);
        // Frame B: bad pattern on digit 1
        add(4'b0001, 1,  3, 0, 16'h4321, 1'b0, 1'b0);
        add(4'b0010, 12, 3, 0, 16'h4321, 1'b0, 1'b0);
        add(4'b0100, 3,  3, 0, 16'h4321, 1'b0, 1'b0);
        add(4'b1000, 4,  3, 1, 16'h43E1, 1'b1, 1'b0);
        // Frame C: dash, 5, 5, blank
        add(4'b0001, 10, 3, 0, 16'h43E1, 1'b1, 1'b0);
        add(4'b0010, 5,  3, 0, 16'h43E1, 1'b1, 1'b0);
        add(4'b0100, 5,  3, 0, 16'h43E1, 1'b1, 1'b0);
        add(4'b1000, 11, 3, 1, 16'hF55A, 1'b0, 1'b0);
        // Short hold on digit 2 must not commit
        add(4'b0001, 7, 3, 0, 16'hF55A, 1'b0, 1'b0);
        add(4'b0010, 8, 3, 0, 16'hF55A, 1'b0, 1'b0);
        add(4'b0100, 6, 2, 0, 16'hF55A, 1'b0, 1'b0);
        add(4'b0000, 6, 1, 0, 16'hF55A, 1'b0, 1'b0);
        add(4'b1000, 9, 3, 0, 16'hF55A, 1'b0, 1'b0);
        add(4'b0100, 6, 3, 1, 16'h9687, 1'b0, 1'b0);
        // Partial frame, then idle across the timeout boundary
        add(4'b0001, 1, 3,  0, 16'h9687, 1'b0, 1'b0);
        add(4'b0010, 2, 3,  0, 16'h9687, 1'b0, 1'b0);
        add(4'b0000, 0, 63, 0, 16'h9687, 1'b0, 1'b0);
        add(4'b0000, 0, 1,  0, 16'h9687, 1'b0, TO_EN);
        add(4'b0100, 5, 3,  0, 16'h9687, 1'b0, TO_EN);
        add(4'b1000, 6, 3,  TO_EN ? 0 : 1, TO_EN ? 16'h9687 : 16'h6521, 1'b0, TO_EN);
        add(4'b0001, 7, 3,  0, TO_EN ? 16'h9687 : 16'h6521, 1'b0, TO_EN);
        add(4'b0010, 8, 3,  TO_EN ? 1 : 0, TO_EN ? 16'h6587 : 16'h6521, 1'b0, 1'b0);
        // Frame D: bad digit 0, overwrites any leftover slots
        add(4'b0001, 12, 3, 0, TO_EN ? 16'h6587 : 16'h6521, 1'b0, 1'b0);
        add(4'b0010, 9,  3, 0, TO_EN ? 16'h6587 : 16'h6521, 1'b0, 1'b0);
        add(4'b0100, 9,  3, 0, TO_EN ? 16'h6587 : 16'h6521, 1'b0, 1'b0);
        add(4'b1000, 9,  3, 1, 16'h999E, 1'b1, 1'b0);

        dig_sel = 4'b0000;
        seg_n   = 7'h7F;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #2;
        check("reset_bcd",   32'(bcd),         32'hFFFF);
        check("reset_fv",    32'(frame_valid), 32'h0);
        check("reset_err",   32'(err),         32'h0);
        check("reset_stale", 32'(stale),       32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[k]) begin
            apply(vecs[k].sel, sn_of(vecs[k].digit), vecs[k].hold, fvs);
            check($sformatf("vec%0d_fv", k),    32'(fvs),   32'(vecs[k].exp_fv));
            check($sformatf("vec%0d_bcd", k),   32'(bcd),   32'(vecs[k].exp_bcd));
            check($sformatf("vec%0d_err", k),   32'(err),   32'(vecs[k].exp_err));
            check($sformatf("vec%0d_stale", k), 32'(stale), 32'(vecs[k].exp_stale));
        end

        // Reset mid-frame: outputs return to reset values at once, working slots are lost
        apply(4'b0001, sn_of(3), 3, fvs);
        check("pre_reset_fv", 32'(fvs), 32'h0);
        rst = 1'b0;
        #1;
        check("midrst_bcd",   32'(bcd),         32'hFFFF);
        check("midrst_fv",    32'(frame_valid), 32'h0);
        check("midrst_err",   32'(err),         32'h0);
        check("midrst_stale", 32'(stale),       32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        total = 0;
        apply(4'b0010, sn_of(2), 3, fvs); total += fvs;
        apply(4'b0100, sn_of(3), 3, fvs); total += fvs;
        apply(4'b1000, sn_of(4), 3, fvs); total += fvs;
        check("post_rst_partial_fv",  32'(total), 32'h0);
        check("post_rst_partial_bcd", 32'(bcd),   32'hFFFF);
        apply(4'b0001, sn_of(1), 3, fvs);
        check("post_rst_frame_fv",  32'(fvs), 32'h1);
        check("post_rst_frame_bcd", 32'(bcd), 32'h4321);
        check("post_rst_frame_err", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
